// File: rtl/mlp_pkg.sv
// Shared definitions for the mlp inference block and its stream loader:
// network dimensions, frame lengths and the loader state encoding.
package mlp_pkg;

    localparam int unsigned MLP_N_IN  = 6;
    localparam int unsigned MLP_N_HID = 16;
    localparam int unsigned MLP_N_OUT = 3;

    // Byte offsets of each parameter array inside a parameter-frame payload
    localparam int unsigned MLP_W1_OFF = 0;
    localparam int unsigned MLP_B1_OFF = MLP_W1_OFF + MLP_N_IN * MLP_N_HID;   // 96
    localparam int unsigned MLP_W2_OFF = MLP_B1_OFF + MLP_N_HID;              // 112
    localparam int unsigned MLP_B2_OFF = MLP_W2_OFF + MLP_N_HID * MLP_N_OUT;  // 160

    localparam int unsigned MLP_PARAM_BYTES = MLP_B2_OFF + MLP_N_OUT;         // 163
    localparam int unsigned MLP_INPUT_BYTES = MLP_N_IN;                       // 6

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_P_LOAD = 2'd1,
        LD_I_LOAD = 2'd2,
        LD_COMMIT = 2'd3
    } loader_state_e;

endpackage

// File: rtl/mlp_stream_loader.sv
// Byte-stream front end for mlp: deserialises parameter and input frames
// from a valid/ready byte stream into the parallel arrays mlp consumes.
// Optional feature: define MLP_LOADER_CHECKSUM_EN to require a trailing
// sum-mod-256 checksum byte on every frame.
module mlp_stream_loader
    import mlp_pkg::*;
#(
    parameter logic [7:0] HDR_PARAM = 8'hA5,
    parameter logic [7:0] HDR_INPUT = 8'h5A
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    output logic [7:0] w1_o  [MLP_N_IN][MLP_N_HID],
    output logic [7:0] b1_o  [MLP_N_HID],
    output logic [7:0] w2_o  [MLP_N_HID][MLP_N_OUT],
    output logic [7:0] b2_o  [MLP_N_OUT],
    output logic [7:0] din_o [MLP_N_IN],
    output logic       params_loaded_o,
    output logic       din_valid_o,
    output logic       err_o
);

`ifdef MLP_LOADER_CHECKSUM_EN
    localparam int unsigned TRAILER_BYTES = 1;
`else
    localparam int unsigned TRAILER_BYTES = 0;
`endif

    // Index of the final byte of each frame (checksum slot when enabled)
    localparam logic [7:0] P_LAST_IDX = 8'(MLP_PARAM_BYTES + TRAILER_BYTES - 1);
    localparam logic [7:0] I_LAST_IDX = 8'(MLP_INPUT_BYTES + TRAILER_BYTES - 1);
    localparam logic [7:0] P_PAYLOAD  = 8'(MLP_PARAM_BYTES);
    localparam logic [7:0] I_PAYLOAD  = 8'(MLP_INPUT_BYTES);

    loader_state_e state_reg, state_next;
    logic [7:0]    idx_reg;
    logic          is_param_reg;
    logic          params_loaded_reg;
    logic          din_valid_reg;
    logic          err_reg;

    logic [7:0] w1_reg  [MLP_N_IN][MLP_N_HID];
    logic [7:0] b1_reg  [MLP_N_HID];
    logic [7:0] w2_reg  [MLP_N_HID][MLP_N_OUT];
    logic [7:0] b2_reg  [MLP_N_OUT];
    logic [7:0] din_reg [MLP_N_IN];

    logic accept;
    logic hdr_param_hit;
    logic hdr_input_hit;
    logic garbage;
    logic in_load;
    logic at_last;
    logic frame_end;
    logic csum_ok;
    logic csum_err;
    logic p_wr;
    logic i_wr;

    logic [MLP_PARAM_BYTES-1:0] p_sel;
    logic [MLP_INPUT_BYTES-1:0] i_sel;

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= LD_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: headers only matter in IDLE, a frame ends on its last slot
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LD_IDLE: begin
                if (hdr_param_hit) begin
                    state_next = LD_P_LOAD;
                end else if (hdr_input_hit) begin
                    state_next = LD_I_LOAD;
                end
            end
            LD_P_LOAD, LD_I_LOAD: begin
                if (frame_end) begin
                    state_next = csum_ok ? LD_COMMIT : LD_IDLE;
                end
            end
            LD_COMMIT: state_next = LD_IDLE;
            default:   state_next = LD_IDLE;
        endcase
    end

    // Output/decode logic: handshake, header classification and write strobes
    always_comb begin
        s_ready_o     = rstn_i && (state_reg != LD_COMMIT);
        accept        = s_valid_i && s_ready_o;
        hdr_param_hit = accept && (state_reg == LD_IDLE) && (s_data_i == HDR_PARAM);
        hdr_input_hit = accept && (state_reg == LD_IDLE) && (s_data_i == HDR_INPUT)
                        && (s_data_i != HDR_PARAM);
        garbage       = accept && (state_reg == LD_IDLE)
                        && (s_data_i != HDR_PARAM) && (s_data_i != HDR_INPUT);
        in_load       = (state_reg == LD_P_LOAD) || (state_reg == LD_I_LOAD);
        at_last       = (state_reg == LD_P_LOAD) ? (idx_reg == P_LAST_IDX)
                                                 : (idx_reg == I_LAST_IDX);
        frame_end     = accept && in_load && at_last;
        csum_err      = frame_end && !csum_ok;
        p_wr          = accept && (state_reg == LD_P_LOAD) && (idx_reg < P_PAYLOAD);
        i_wr          = accept && (state_reg == LD_I_LOAD) && (idx_reg < I_PAYLOAD);
    end

`ifdef MLP_LOADER_CHECKSUM_EN
    logic [7:0] sum_reg;

    // Running payload sum, restarted while idle so each frame starts from zero
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sum_reg <= '0;
        end else if (state_reg == LD_IDLE) begin
            sum_reg <= '0;
        end else if (p_wr || i_wr) begin
            sum_reg <= sum_reg + s_data_i;
        end
    end

    assign csum_ok = (s_data_i == sum_reg);
`else
    assign csum_ok = 1'b1;
`endif

    // Payload index: zero while idle, advances per payload byte, saturates on the last slot
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idx_reg <= '0;
        end else if (state_reg == LD_IDLE) begin
            idx_reg <= '0;
        end else if (accept && in_load && !at_last) begin
            idx_reg <= idx_reg + 8'd1;
        end
    end

    // Remember which frame type is in flight so COMMIT knows what to flag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            is_param_reg <= 1'b0;
        end else if (hdr_param_hit) begin
            is_param_reg <= 1'b1;
        end else if (hdr_input_hit) begin
            is_param_reg <= 1'b0;
        end
    end

    // One-hot write selects, one per payload position
    for (genvar gi = 0; gi < MLP_PARAM_BYTES; gi++) begin : g_p_sel
        assign p_sel[gi] = p_wr && (idx_reg == 8'(gi));
    end
    for (genvar gi = 0; gi < MLP_INPUT_BYTES; gi++) begin : g_i_sel
        assign i_sel[gi] = i_wr && (idx_reg == 8'(gi));
    end

    // Array registers: each byte lands in place as soon as it is accepted
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < MLP_N_IN; i++) begin
                din_reg[i] <= '0;
                for (int j = 0; j < MLP_N_HID; j++) begin
                    w1_reg[i][j] <= '0;
                end
            end
            for (int k = 0; k < MLP_N_HID; k++) begin
                b1_reg[k] <= '0;
                for (int m = 0; m < MLP_N_OUT; m++) begin
                    w2_reg[k][m] <= '0;
                end
            end
            for (int m = 0; m < MLP_N_OUT; m++) begin
                b2_reg[m] <= '0;
            end
        end else begin
            for (int i = 0; i < MLP_N_IN; i++) begin
                if (i_sel[i]) din_reg[i] <= s_data_i;
                for (int j = 0; j < MLP_N_HID; j++) begin
                    if (p_sel[MLP_W1_OFF + i * MLP_N_HID + j]) w1_reg[i][j] <= s_data_i;
                end
            end
            for (int k = 0; k < MLP_N_HID; k++) begin
                if (p_sel[MLP_B1_OFF + k]) b1_reg[k] <= s_data_i;
                for (int m = 0; m < MLP_N_OUT; m++) begin
                    if (p_sel[MLP_W2_OFF + k * MLP_N_OUT + m]) w2_reg[k][m] <= s_data_i;
                end
            end
            for (int m = 0; m < MLP_N_OUT; m++) begin
                if (p_sel[MLP_B2_OFF + m]) b2_reg[m] <= s_data_i;
            end
        end
    end

    // Status flags: loaded/valid are raised leaving COMMIT, error is sticky
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            params_loaded_reg <= 1'b0;
            din_valid_reg     <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            din_valid_reg <= (state_reg == LD_COMMIT) && !is_param_reg;
            if ((state_reg == LD_COMMIT) && is_param_reg) begin
                params_loaded_reg <= 1'b1;
            end else if (hdr_param_hit) begin
                params_loaded_reg <= 1'b0;
            end
            if (garbage || csum_err) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign w1_o            = w1_reg;
    assign b1_o            = b1_reg;
    assign w2_o            = w2_reg;
    assign b2_o            = b2_reg;
    assign din_o           = din_reg;
    assign params_loaded_o = params_loaded_reg;
    assign din_valid_o     = din_valid_reg;
    assign err_o           = err_reg;

endmodule

// File: tb/tb_mlp_stream_loader.sv
// Self-checking bench for mlp_stream_loader. Holds a flat payload-image
// model of the frame format and compares every output array against it.
// Checksum scenarios run when MLP_LOADER_CHECKSUM_EN is defined.
module tb_mlp_stream_loader;
    import mlp_pkg::*;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic [7:0] s_data_i = 8'h00;
    logic       s_valid_i = 1'b0;
    logic       s_ready_o;
    logic [7:0] w1_o  [MLP_N_IN][MLP_N_HID];
    logic [7:0] b1_o  [MLP_N_HID];
    logic [7:0] w2_o  [MLP_N_HID][MLP_N_OUT];
    logic [7:0] b2_o  [MLP_N_OUT];
    logic [7:0] din_o [MLP_N_IN];
    logic       params_loaded_o;
    logic       din_valid_o;
    logic       err_o;

    mlp_stream_loader #(.HDR_PARAM(8'hA5), .HDR_INPUT(8'h5A)) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .s_data_i        (s_data_i),
        .s_valid_i       (s_valid_i),
        .s_ready_o       (s_ready_o),
        .w1_o            (w1_o),
        .b1_o            (b1_o),
        .w2_o            (w2_o),
        .b2_o            (b2_o),
        .din_o           (din_o),
        .params_loaded_o (params_loaded_o),
        .din_valid_o     (din_valid_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int dv_count = 0;

    // Reference model: payload image as laid out on the wire
    logic [7:0] exp_par [MLP_PARAM_BYTES];
    logic [7:0] exp_din [MLP_INPUT_BYTES];
    logic       exp_loaded = 1'b0;
    logic       exp_err = 1'b0;
    logic [7:0] pay [MLP_PARAM_BYTES];

    // Count din_valid pulses away from the active edge
    always @(negedge clk_i) begin
        if (din_valid_o === 1'b1) dv_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < MLP_PARAM_BYTES; k++) exp_par[k] = 8'h00;
        for (int k = 0; k < MLP_INPUT_BYTES; k++) exp_din[k] = 8'h00;
        exp_loaded = 1'b0;
        exp_err    = 1'b0;
    endtask

    // Every array element against the payload image
    task automatic compare_all(input string tag);
        for (int i = 0; i < MLP_N_IN; i++)
            for (int j = 0; j < MLP_N_HID; j++)
                chk($sformatf("%s w1[%0d][%0d]", tag, i, j), w1_o[i][j], exp_par[i * 16 + j]);
        for (int k = 0; k < MLP_N_HID; k++)
            chk($sformatf("%s b1[%0d]", tag, k), b1_o[k], exp_par[96 + k]);
        for (int k = 0; k < MLP_N_HID; k++)
            for (int m = 0; m < MLP_N_OUT; m++)
                chk($sformatf("%s w2[%0d][%0d]", tag, k, m), w2_o[k][m], exp_par[112 + k * 3 + m]);
        for (int m = 0; m < MLP_N_OUT; m++)
            chk($sformatf("%s b2[%0d]", tag, m), b2_o[m], exp_par[160 + m]);
        for (int i = 0; i < MLP_N_IN; i++)
            chk($sformatf("%s din[%0d]", tag, i), din_o[i], exp_din[i]);
    endtask

    // Offer one byte (after optional random idle cycles); returns at accept edge + 1
    task automatic send_byte(input logic [7:0] b, input int stall_pct);
        int guard = 0;
        while (int'($urandom_range(99)) < stall_pct) begin
            s_valid_i = 1'b0;
            s_data_i  = 8'($urandom);
            @(posedge clk_i); #1;
        end
        s_data_i  = b;
        s_valid_i = 1'b1;
        while (s_ready_o !== 1'b1 && guard < 40) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (guard >= 40) chk("ready_timeout", s_ready_o, 1);
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
    endtask

    // Header + first n_send payload bytes of pay[]; full frames get a checksum when enabled
    task automatic send_frame(input bit is_param, input int n_send, input int stall_pct,
                              input logic [7:0] csum_delta);
        int len = is_param ? MLP_PARAM_BYTES : MLP_INPUT_BYTES;
        logic [7:0] sum = 8'h00;
        send_byte(is_param ? 8'hA5 : 8'h5A, stall_pct);
        if (is_param) exp_loaded = 1'b0;
        for (int k = 0; k < len && k < n_send; k++) begin
            send_byte(pay[k], stall_pct);
            sum = sum + pay[k];
            if (is_param) exp_par[k] = pay[k];
            else          exp_din[k] = pay[k];
        end
`ifdef MLP_LOADER_CHECKSUM_EN
        if (n_send >= len) send_byte(sum + csum_delta, stall_pct);
`endif
    endtask

    // Called just after the final byte of a frame was accepted
    task automatic check_commit(input string tag, input bit is_param, input bit expect_ok);
        int dv0 = dv_count;
        if (expect_ok) begin
            chk({tag, " ready_in_commit"}, s_ready_o, 0);
            chk({tag, " flag_not_early"}, is_param ? params_loaded_o : din_valid_o, 0);
            @(posedge clk_i); #1;
            if (is_param) begin
                exp_loaded = 1'b1;
                chk({tag, " params_loaded_rise"}, params_loaded_o, 1);
            end else begin
                chk({tag, " din_valid_high"}, din_valid_o, 1);
            end
            chk({tag, " ready_after_commit"}, s_ready_o, 1);
            @(posedge clk_i); #1;
            chk({tag, " din_valid_low"}, din_valid_o, 0);
            chk({tag, " din_valid_pulses"}, dv_count - dv0, is_param ? 0 : 1);
        end else begin
            exp_err = 1'b1;
            chk({tag, " ready_no_commit"}, s_ready_o, 1);
            @(posedge clk_i); #1;
            @(posedge clk_i); #1;
            chk({tag, " no_din_valid"}, dv_count - dv0, 0);
        end
        chk({tag, " params_loaded"}, params_loaded_o, exp_loaded);
        chk({tag, " err"}, err_o, exp_err);
    endtask

    initial begin
        model_clear();

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst ready_low", s_ready_o, 0);
        chk("rst params_loaded", params_loaded_o, 0);
        chk("rst din_valid", din_valid_o, 0);
        chk("rst err", err_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        chk("idle ready", s_ready_o, 1);
        compare_all("rst");

        // Parameter frame with payload byte n = n
        for (int k = 0; k < MLP_PARAM_BYTES; k++) pay[k] = 8'(k);
        send_frame(1'b1, MLP_PARAM_BYTES, 0, 8'h00);
        check_commit("ramp", 1'b1, 1'b1);
        chk("ramp w1[0][0]", w1_o[0][0], 0);
        chk("ramp w1[5][15]", w1_o[5][15], 95);
        chk("ramp b1[0]", b1_o[0], 96);
        chk("ramp w2[0][0]", w2_o[0][0], 112);
        chk("ramp b2[2]", b2_o[2], 162);
        compare_all("ramp");

        // Input frame 01..06
        for (int k = 0; k < MLP_INPUT_BYTES; k++) pay[k] = 8'(k + 1);
        send_frame(1'b0, MLP_INPUT_BYTES, 0, 8'h00);
        check_commit("in16", 1'b0, 1'b1);
        for (int k = 0; k < MLP_INPUT_BYTES; k++) chk("in16 din_const", din_o[k], k + 1);

        // Garbage byte in IDLE, then a valid input frame containing header values
        send_byte(8'h33, 0);
        exp_err = 1'b1;
        chk("garbage err", err_o, 1);
        chk("garbage ready", s_ready_o, 1);
        pay[0] = 8'hA5; pay[1] = 8'h5A;
        for (int k = 2; k < MLP_INPUT_BYTES; k++) pay[k] = 8'($urandom);
        send_frame(1'b0, MLP_INPUT_BYTES, 0, 8'h00);
        check_commit("after_garbage", 1'b0, 1'b1);
        compare_all("after_garbage");

        // Random parameter frame with random valid stalls
        for (int k = 0; k < MLP_PARAM_BYTES; k++) pay[k] = 8'($urandom);
        pay[3] = 8'hA5; pay[70] = 8'h5A; pay[162] = 8'hA5;
        send_frame(1'b1, MLP_PARAM_BYTES, 40, 8'h00);
        check_commit("stall", 1'b1, 1'b1);
        compare_all("stall");

        // Asynchronous reset after 50 parameter bytes
        for (int k = 0; k < MLP_PARAM_BYTES; k++) pay[k] = 8'($urandom_range(255, 1));
        send_frame(1'b1, 50, 10, 8'h00);
        chk("partial params_loaded", params_loaded_o, 0);
        #2;
        rstn_i = 1'b0;
        #1;
        model_clear();
        chk("midrst ready_low", s_ready_o, 0);
        chk("midrst params_loaded", params_loaded_o, 0);
        chk("midrst err", err_o, 0);
        compare_all("midrst");
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        for (int k = 0; k < MLP_PARAM_BYTES; k++) pay[k] = 8'($urandom);
        send_frame(1'b1, MLP_PARAM_BYTES, 20, 8'h00);
        check_commit("post_rst", 1'b1, 1'b1);
        compare_all("post_rst");

`ifdef MLP_LOADER_CHECKSUM_EN
        // Correct checksum (0x15) commits; 0x16 errors without a pulse
        for (int k = 0; k < MLP_INPUT_BYTES; k++) pay[k] = 8'(k + 1);
        send_frame(1'b0, MLP_INPUT_BYTES, 0, 8'h00);
        check_commit("csum_ok", 1'b0, 1'b1);
        send_frame(1'b0, MLP_INPUT_BYTES, 0, 8'h01);
        check_commit("csum_bad", 1'b0, 1'b0);
        compare_all("csum_bad");
        for (int k = 0; k < MLP_PARAM_BYTES; k++) pay[k] = 8'($urandom);
        send_frame(1'b1, MLP_PARAM_BYTES, 0, 8'h80);
        check_commit("csum_bad_param", 1'b1, 1'b0);
        compare_all("csum_bad_param");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
